lock_sequencer: RTL and testbench
=================================

// Module: lock_sequencer
// PURPOSE
//  Sequencing controller for the combination-lock datapath. Counts digits entered
//  via Validate, drives shift/clear/commit strobes, samples the datapath compare
//  result, and tracks failed attempts with a timed lockout and alarm. Sits between
//  the button debouncers and the datapath; drives the display mode select.
// PARAMETERS
//  DIGITS          4          digits per code entry (>=1)
//  MAX_TRIES       3          consecutive failed checks that trigger LOCKOUT (>=1)
//  LOCKOUT_CYCLES  100000000  LOCKOUT duration in clock cycles (1 s at 100 MHz)
//  IDLE_CYCLES     500000000  auto-relock timeout in OPEN (used only with macro)
//  TIMER_W         29         timer width; must hold max(LOCKOUT_CYCLES, IDLE_CYCLES)
// PORTS
//  Clock        in   1  system clock; all state changes on the rising edge
//  Reset        in   1  asynchronous, active-low reset
//  Open_Close   in   1  debounced single-cycle pulse: relock / abort
//  Validate     in   1  debounced single-cycle pulse: accept current digit
//  Change       in   1  debounced single-cycle pulse: start code change (OPEN only)
//  Match        in   1  datapath: entry register equals stored code (combinational)
//  ShiftA       out  1  one-cycle strobe: shift the digit into the entry register
//  ShiftB       out  1  one-cycle strobe: shift the digit into the staging register
//  CommitB      out  1  one-cycle strobe: copy staging into the stored-code register
//  ClearEntry   out  1  one-cycle strobe: clear the entry register
//  Unlocked     out  1  level: lock is open
//  Alarm        out  1  level: high throughout LOCKOUT
//  Selector     out  3  display mode: 0 LOCKED, 1 ENTRY, 2 OPEN, 3 CHANGE, 4 LOCKOUT
// BEHAVIOUR
//  - All outputs are registered. On reset: state LOCKED; all strobes 0; Unlocked 0;
//    Alarm 0; Selector 0; digit count, fail count and timer 0.
//  - Strobes are high exactly one cycle, in the cycle after the causing input pulse.
//  - Input priority within a cycle: Open_Close > Change > Validate. Lower-priority
//    pulses in the same cycle are dropped.
//  - LOCKED/ENTRY: Validate -> ShiftA and count+1; state ENTRY after the first digit.
//    When the DIGITS-th digit is accepted -> CHECK. Open_Close -> ClearEntry, count 0,
//    LOCKED. Change is ignored.
//  - CHECK (1 cycle, after the last ShiftA has taken effect): sample Match.
//    Match=1 -> OPEN, fail count 0, ClearEntry.
//    Match=0 -> fail+1 and ClearEntry. If fail == MAX_TRIES -> LOCKOUT, timer =
//    LOCKOUT_CYCLES-1; otherwise -> LOCKED. Inputs arriving during CHECK are dropped.
//  - OPEN: Unlocked=1. Open_Close -> LOCKED (Unlocked 0 next cycle). Change -> CHANGE,
//    count 0. Validate is ignored.
//  - CHANGE: Unlocked stays 1. Validate -> ShiftB, count+1. On the DIGITS-th digit,
//    CommitB is issued in the same cycle as that ShiftB's successor cycle (one cycle
//    after the final ShiftB), then -> OPEN. Open_Close -> OPEN with no CommitB; the
//    stored code is unchanged. A second Change restarts entry (count 0).
//  - LOCKOUT: Alarm=1; all inputs are ignored. The timer decrements every cycle.
//    At timer==0 -> LOCKED; Alarm 0, fail count 0.
//  - Counters saturate and never wrap. The fail count persists across LOCKED/ENTRY
//    and is cleared only by a successful check, the end of LOCKOUT, or reset.
//  - Reset asserted mid-operation: immediate return to the reset state. No CommitB
//    is issued, and any partially shifted staging data is never committed.
// CONFIGURATION
//  - LOCK_AUTORELOCK_EN defined: in OPEN, the timer loads IDLE_CYCLES-1 on entry and
//    reloads on any input pulse. At timer==0 -> LOCKED with Unlocked 0.
//    CHANGE is exempt from the timeout.
//  - Not defined: OPEN persists until Open_Close. No idle timer logic is synthesised.
// TESTING  (DIGITS=4, MAX_TRIES=3, LOCKOUT_CYCLES=20, IDLE_CYCLES=50)
//  - Reset low mid-ENTRY -> all outputs 0 asynchronously; Selector=0 after release.
//  - 4 Validate pulses, Match=1 -> 4 ShiftA, then CHECK, then Unlocked=1, Selector=2.
//  - 3 failed 4-digit entries -> Alarm=1, Selector=4 for exactly 20 cycles.
//    Validate during LOCKOUT yields no ShiftA. Then LOCKED, Alarm=0.
//  - OPEN, Change, 4 Validate -> 4 ShiftB, then one CommitB, then OPEN.
//    Repeat with Open_Close after 2 digits -> no CommitB.
//  - Open_Close and Validate in the same cycle in ENTRY after 2 digits ->
//    ClearEntry only, no ShiftA, count 0.
//  - LOCK_AUTORELOCK_EN: OPEN idle 50 cycles -> Unlocked=0. A Validate pulse at
//    cycle 40 restarts the count, so relock occurs 50 cycles after that pulse.

Source files
------------

// File: rtl/lock_sequencer.sv
// lock_sequencer
//   Sequencing controller for the combination-lock datapath. It counts digits
//   accepted via Validate and drives the shift/clear/commit strobes. It samples
//   the datapath compare result and tracks failed attempts, which lead to a timed
//   lockout with alarm. It also drives the display mode select.
//
//   Optional feature: define LOCK_AUTORELOCK_EN to relock automatically after
//   IDLE_CYCLES of inactivity in OPEN. CHANGE is exempt from this timeout.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_open_close   single-cycle pulse: relock / abort
//   i_validate     single-cycle pulse: accept current digit
//   i_change       single-cycle pulse: start code change (OPEN only)
//   i_match        datapath: entry register equals stored code
//   o_shift_a      strobe: shift digit into entry register
//   o_shift_b      strobe: shift digit into staging register
//   o_commit_b     strobe: copy staging into stored-code register
//   o_clear_entry  strobe: clear entry register
//   o_unlocked     level: lock open
//   o_alarm        level: high throughout LOCKOUT
//   o_selector     display mode: 0 LOCKED, 1 ENTRY, 2 OPEN, 3 CHANGE, 4 LOCKOUT
module lock_sequencer #(
  parameter int DIGITS         = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 100000000,
  parameter int IDLE_CYCLES    = 500000000,
  parameter int TIMER_W        = 29
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_open_close,
  input  logic       i_validate,
  input  logic       i_change,
  input  logic       i_match,
  output logic       o_shift_a,
  output logic       o_shift_b,
  output logic       o_commit_b,
  output logic       o_clear_entry,
  output logic       o_unlocked,
  output logic       o_alarm,
  output logic [2:0] o_selector
);

  localparam int CNT_W  = $clog2(DIGITS + 1);
  localparam int FAIL_W = $clog2(MAX_TRIES + 1);

  localparam logic [CNT_W-1:0]   LAST_DIGIT = CNT_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0]   ALL_DIGITS = CNT_W'(DIGITS);
  localparam logic [FAIL_W-1:0]  LAST_FAIL  = FAIL_W'(MAX_TRIES - 1);
  localparam logic [FAIL_W-1:0]  ALL_FAILS  = FAIL_W'(MAX_TRIES);
  localparam logic [TIMER_W-1:0] LOCK_LOAD  = TIMER_W'(LOCKOUT_CYCLES - 1);
`ifdef LOCK_AUTORELOCK_EN
  localparam logic [TIMER_W-1:0] IDLE_LOAD  = TIMER_W'(IDLE_CYCLES - 1);
`endif

  localparam logic [2:0] SEL_LOCKED  = 3'd0;
  localparam logic [2:0] SEL_ENTRY   = 3'd1;
  localparam logic [2:0] SEL_OPEN    = 3'd2;
  localparam logic [2:0] SEL_CHANGE  = 3'd3;
  localparam logic [2:0] SEL_LOCKOUT = 3'd4;

  // Reject a timer too narrow for either load value at elaboration time.
  if (((64'(LOCKOUT_CYCLES) - 64'd1) >> TIMER_W) != 64'd0 ||
      ((64'(IDLE_CYCLES) - 64'd1) >> TIMER_W) != 64'd0) begin : g_bad_timer_w
    $error("lock_sequencer: TIMER_W too narrow for LOCKOUT_CYCLES/IDLE_CYCLES");
  end

  // SETTLE gives the final ShiftA one cycle to land in the entry register, so
  // CHECK sees a Match computed from the complete code.
  // COMMIT is the cycle after the final ShiftB, where CommitB fires.
  typedef enum logic [2:0] {
    S_LOCKED, S_ENTRY, S_SETTLE, S_CHECK, S_OPEN, S_CHANGE, S_COMMIT, S_LOCKOUT
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [FAIL_W-1:0]   r_fail;
  logic [TIMER_W-1:0]  r_timer;

  // Input priority: Open_Close > Change > Validate. A lower-priority input that
  // arrives in the same cycle as a higher-priority one is dropped.
  logic w_oc, w_chg, w_val;
  assign w_oc  = i_open_close;
  assign w_chg = i_change & ~i_open_close;
  assign w_val = i_validate & ~i_open_close & ~i_change;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_LOCKED;
      r_cnt         <= '0;
      r_fail        <= '0;
      r_timer       <= '0;
      o_shift_a     <= 1'b0;
      o_shift_b     <= 1'b0;
      o_commit_b    <= 1'b0;
      o_clear_entry <= 1'b0;
      o_unlocked    <= 1'b0;
      o_alarm       <= 1'b0;
      o_selector    <= SEL_LOCKED;
    end else begin
      o_shift_a     <= 1'b0;
      o_shift_b     <= 1'b0;
      o_commit_b    <= 1'b0;
      o_clear_entry <= 1'b0;
      case (r_state)
        S_LOCKED, S_ENTRY: begin
          if (w_oc) begin
            o_clear_entry <= 1'b1;
            r_cnt         <= '0;
            r_state       <= S_LOCKED;
            o_selector    <= SEL_LOCKED;
          end else if (w_val) begin
            o_shift_a  <= 1'b1;
            o_selector <= SEL_ENTRY;
            if (r_cnt == LAST_DIGIT) begin
              r_cnt   <= ALL_DIGITS;
              r_state <= S_SETTLE;
            end else begin
              r_cnt   <= r_cnt + 1'b1;
              r_state <= S_ENTRY;
            end
          end
        end
        S_SETTLE: r_state <= S_CHECK;
        S_CHECK: begin
          o_clear_entry <= 1'b1;
          r_cnt         <= '0;
          if (i_match) begin
            r_fail     <= '0;
            r_state    <= S_OPEN;
            o_unlocked <= 1'b1;
            o_selector <= SEL_OPEN;
`ifdef LOCK_AUTORELOCK_EN
            r_timer    <= IDLE_LOAD;
`endif
          end else if (r_fail >= LAST_FAIL) begin
            r_fail     <= ALL_FAILS;
            r_state    <= S_LOCKOUT;
            r_timer    <= LOCK_LOAD;
            o_alarm    <= 1'b1;
            o_selector <= SEL_LOCKOUT;
          end else begin
            r_fail     <= r_fail + 1'b1;
            r_state    <= S_LOCKED;
            o_selector <= SEL_LOCKED;
          end
        end
        S_OPEN: begin
          if (w_oc) begin
            r_state    <= S_LOCKED;
            o_unlocked <= 1'b0;
            o_selector <= SEL_LOCKED;
          end else if (w_chg) begin
            r_cnt      <= '0;
            r_state    <= S_CHANGE;
            o_selector <= SEL_CHANGE;
          end
`ifdef LOCK_AUTORELOCK_EN
          // Validate does nothing in OPEN except restart the idle timeout.
          else if (w_val) begin
            r_timer <= IDLE_LOAD;
          end else if (r_timer == '0) begin
            r_state    <= S_LOCKED;
            o_unlocked <= 1'b0;
            o_selector <= SEL_LOCKED;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
`endif
        end
        S_CHANGE: begin
          if (w_oc) begin
            r_cnt      <= '0;
            r_state    <= S_OPEN;
            o_selector <= SEL_OPEN;
`ifdef LOCK_AUTORELOCK_EN
            r_timer    <= IDLE_LOAD;
`endif
          end else if (w_chg) begin
            r_cnt <= '0;
          end else if (w_val) begin
            o_shift_b <= 1'b1;
            if (r_cnt == LAST_DIGIT) begin
              r_cnt   <= ALL_DIGITS;
              r_state <= S_COMMIT;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_COMMIT: begin
          o_commit_b <= 1'b1;
          r_cnt      <= '0;
          r_state    <= S_OPEN;
          o_selector <= SEL_OPEN;
`ifdef LOCK_AUTORELOCK_EN
          r_timer    <= IDLE_LOAD;
`endif
        end
        S_LOCKOUT: begin
          if (r_timer == '0) begin
            r_state    <= S_LOCKED;
            r_fail     <= '0;
            o_alarm    <= 1'b0;
            o_selector <= SEL_LOCKED;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        default: begin
          r_state    <= S_LOCKED;
          o_unlocked <= 1'b0;
          o_alarm    <= 1'b0;
          o_selector <= SEL_LOCKED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lock_sequencer.sv
module tb_lock_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       oc, val, chg, match;
  logic       sha, shb, cmb, clr, unl, alm;
  logic [2:0] sel;

  int n_vec  = 0;
  int n_fail = 0;
  int n_cmb  = 0;
  int n_sha  = 0;
  int cyc;

  lock_sequencer #(
    .DIGITS(4), .MAX_TRIES(3), .LOCKOUT_CYCLES(20), .IDLE_CYCLES(50), .TIMER_W(8)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_open_close(oc), .i_validate(val),
    .i_change(chg), .i_match(match), .o_shift_a(sha), .o_shift_b(shb),
    .o_commit_b(cmb), .o_clear_entry(clr), .o_unlocked(unl), .o_alarm(alm),
    .o_selector(sel)
  );

  always #5 clk = ~clk;

  // Strobe counters, sampled on the falling edge.
  always @(negedge clk) begin
    if (cmb) n_cmb++;
    if (sha) n_sha++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Drive one single-cycle pulse; returns 1ns after the edge that sampled it,
  // where the registered response is visible.
  task automatic pulse(input logic p_oc, input logic p_chg, input logic p_val);
    @(posedge clk); #1;
    oc = p_oc; chg = p_chg; val = p_val;
    @(posedge clk); #1;
    oc = 1'b0; chg = 1'b0; val = 1'b0;
  endtask

  task automatic all_zero(input string tag);
    chk(tag, {25'd0, sha, shb, cmb, clr, unl, alm, sel}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; oc = 1'b0; val = 1'b0; chg = 1'b0; match = 1'b0;
    tick(2);
    all_zero("reset_state");
    rst_n = 1'b1;
    tick(1);
    all_zero("after_release");

    // Correct code entry
    match = 1'b1;
    pulse(0, 0, 1);
    chk("entry_d1_shifta", sha, 1);
    chk("entry_d1_sel", sel, 1);
    pulse(0, 0, 1); pulse(0, 0, 1);
    pulse(0, 0, 1);
    chk("entry_d4_shifta", sha, 1);
    tick(1);
    chk("check_no_unlock_yet", unl, 0);
    tick(1);
    chk("open_clear", clr, 1);
    chk("open_unlocked", unl, 1);
    chk("open_sel", sel, 2);

    // Code change, full entry
    n_cmb = 0;
    pulse(0, 1, 0);
    chk("change_sel", sel, 3);
    for (int i = 0; i < 4; i++) begin
      pulse(0, 0, 1);
      chk("change_shiftb", shb, 1);
      chk("change_no_early_commit", cmb, 0);
    end
    tick(1);
    chk("commit_strobe", cmb, 1);
    chk("commit_sel_open", sel, 2);
    tick(2);
    chk("commit_count", n_cmb, 1);
    chk("commit_unlocked", unl, 1);

    // Code change aborted after 2 digits
    n_cmb = 0;
    pulse(0, 1, 0);
    pulse(0, 0, 1); pulse(0, 0, 1);
    pulse(1, 0, 0);
    chk("abort_sel_open", sel, 2);
    tick(3);
    chk("abort_no_commit", n_cmb, 0);
    chk("abort_unlocked", unl, 1);

    // Relock
    pulse(1, 0, 0);
    chk("relock_unlocked", unl, 0);
    chk("relock_sel", sel, 0);

    // Async reset mid-entry
    pulse(0, 0, 1); pulse(0, 0, 1);
    chk("pre_reset_sel", sel, 1);
    #3 rst_n = 1'b0;
    #1 all_zero("async_reset");
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk("post_reset_sel", sel, 0);

    // Open_Close + Validate together after 2 digits
    match = 1'b1;
    pulse(0, 0, 1); pulse(0, 0, 1);
    pulse(1, 0, 1);
    chk("ocv_clear", clr, 1);
    chk("ocv_no_shifta", sha, 0);
    chk("ocv_sel", sel, 0);
    // count is back at 0: three digits must not reach CHECK, the fourth does
    pulse(0, 0, 1); pulse(0, 0, 1); pulse(0, 0, 1);
    tick(3);
    chk("ocv_count_reset", unl, 0);
    pulse(0, 0, 1);
    tick(2);
    chk("ocv_fourth_opens", unl, 1);
    pulse(1, 0, 0);

    // Three failed entries -> lockout
    match = 1'b0;
    for (int t = 0; t < 3; t++) begin
      repeat (4) pulse(0, 0, 1);
      tick(2);
      chk("fail_clear", clr, 1);
      chk("fail_unlocked", unl, 0);
      if (t < 2) begin
        chk("fail_sel_locked", sel, 0);
        chk("fail_no_alarm", alm, 0);
      end
    end
    chk("lockout_alarm", alm, 1);
    chk("lockout_sel", sel, 4);
    n_sha = 0;
    cyc = 1;
    for (int i = 0; i < 40; i++) begin
      if (i == 5) val = 1'b1;
      if (i == 6) val = 1'b0;
      tick(1);
      if (alm) cyc++;
    end
    chk("lockout_cycles", cyc, 20);
    chk("lockout_no_shifta", n_sha, 0);
    chk("lockout_end_alarm", alm, 0);
    chk("lockout_end_sel", sel, 0);

    // Fail count cleared by lockout: one failure must not lock out again
    repeat (4) pulse(0, 0, 1);
    tick(2);
    chk("post_lockout_fail_sel", sel, 0);
    chk("post_lockout_fail_alarm", alm, 0);

`ifdef LOCK_AUTORELOCK_EN
    // Idle relock
    match = 1'b1;
    repeat (4) pulse(0, 0, 1);
    tick(2);
    chk("idle_open", unl, 1);
    cyc = 1;
    for (int i = 0; i < 100 && unl; i++) begin
      tick(1);
      if (unl) cyc++;
    end
    chk("idle_relock_cycles", cyc, 50);
    chk("idle_relock_sel", sel, 0);
    // Validate at cycle 40 of OPEN restarts the timeout
    repeat (4) pulse(0, 0, 1);
    tick(2);
    tick(38);
    pulse(0, 0, 1);
    cyc = 0;
    for (int i = 0; i < 100 && unl; i++) begin
      tick(1);
      cyc++;
    end
    chk("idle_restart_cycles", cyc, 50);
    chk("idle_restart_unlocked", unl, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
